uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmit FIFO write port (`tx_byte`/`tx_valid`) between several on-chip byte-stream requesters. It sits between the requesters and the UART register/FIFO block and respects `fifo_tx_full` backpressure. Each grant is locked for a whole packet, delimited by `last`, so bytes from different requesters never interleave on the wire. An optional watchdog releases a grant held by a requester that stalls mid-packet.

---
 rtl/uart_arb_pkg.sv | 41 ++++
 rtl/uart_arb_watchdog.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared types and helpers for the UART TX arbiter.
//   arb_state_e : arbiter FSM states (IDLE, LOCK)
//   MAX_REQ     : largest supported requester count
//   rr_pick     : round-robin winner selection, request vector + pointer
//                 in, one-hot winner out (all zero when nothing requests)
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_REQ = 16;

    // Scan n positions starting at ptr, wrapping modulo n; the first set
    // request bit wins. Vectors are sized for MAX_REQ so one function serves
    // every N_REQ; the caller truncates the result to its own width.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [3:0]         ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] win;
        logic               found;
        logic [3:0]         idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                idx = 4'((32'(ptr) + i) % n);
                if (!found && req[idx]) begin
                    win[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/uart_arb_watchdog.sv
// uart_arb_watchdog
// Stall counter for the grant owner. Counts LOCK cycles where the owner is
// not presenting a byte; any transfer, leaving LOCK, or expiry clears it.
// Cycles where the owner is valid but the FIFO is full neither count nor
// clear. Only instantiated when UART_ARB_TIMEOUT_EN is defined.
//   clk, reset_n : clock, async active-low reset
//   lock         : arbiter is in LOCK
//   owner_valid  : req_valid of the current owner
//   transfer     : a byte is written this cycle
//   expire       : combinational, owner has stalled TIMEOUT_CYCLES-1 cycles
//                  and is still not valid
module uart_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic lock,
    input  logic owner_valid,
    input  logic transfer,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    assign expire = lock && !owner_valid && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!lock || transfer || expire) begin
            cnt <= '0;
        end else if (!owner_valid) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing the UART TX FIFO write port between N_REQ
// byte-stream requesters. A grant is locked for a whole packet (until a
// transfer with last) so packets never interleave.
// Optional feature: define UART_ARB_TIMEOUT_EN to add a stall watchdog that
// revokes a grant whose owner stops presenting bytes mid-packet.
//
// Handshake: a byte moves from requester k to the FIFO in any cycle where
// req_valid_i[k] and req_ready_o[k] are both high; that same cycle has
// tx_valid high. ready never depends on valid of the same requester, and
// is low for every requester in IDLE and whenever fifo_tx_full is high.
//
// Ports:
//   clk, reset_n  : clock, async active-low reset
//   req_valid_i   : per-requester byte valid
//   req_data_i    : per-requester byte, requester k on [8k+7:8k]
//   req_last_i    : per-requester end-of-packet flag
//   req_ready_o   : per-requester accept (combinational)
//   fifo_tx_full  : TX FIFO full, blocks writes
//   tx_byte       : byte to TX FIFO (combinational)
//   tx_valid      : TX FIFO write strobe (combinational)
//   grant_o       : registered one-hot owner, zero when idle
//   busy_o        : registered, FSM is in LOCK (exposes FSM state)
//   timeout_o     : registered one-cycle pulse on watchdog revoke
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [N_REQ*8-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    input  logic               fifo_tx_full,
    output logic [7:0]         tx_byte,
    output logic               tx_valid,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             timeout_q, timeout_d;

    logic [PTR_W-1:0] owner_idx;
    logic [7:0]       owner_data;
    logic             owner_valid;
    logic             owner_last;
    logic [PTR_W-1:0] after_owner;
    logic             expire;

    // grant_q is one-hot in LOCK and zero in IDLE, so masking with it
    // selects the owner's signals and yields zero when idle.
    assign owner_valid = |(req_valid_i & grant_q);
    assign owner_last  = |(req_last_i & grant_q);

    always_comb begin
        owner_idx  = '0;
        owner_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_q[k]) begin
                owner_idx  = PTR_W'(k);
                owner_data = req_data_i[8*k +: 8];
            end
        end
    end

    assign after_owner = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    uart_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .reset_n     (reset_n),
        .lock        (state_q == LOCK),
        .owner_valid (owner_valid),
        .transfer    (tx_valid),
        .expire      (expire)
    );
`else
    // No watchdog: the grant is held until last. The parameter is still
    // referenced so both builds share one parameter list.
    assign expire = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        timeout_d   = 1'b0;
        req_ready_o = '0;
        tx_valid    = 1'b0;
        tx_byte     = '0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    grant_d = N_REQ'(rr_pick(MAX_REQ'(req_valid_i), 4'(rr_ptr_q), N_REQ));
                    state_d = LOCK;
                end
            end
            LOCK: begin
                req_ready_o = grant_q & {N_REQ{!fifo_tx_full}};
                tx_valid    = owner_valid & !fifo_tx_full;
                tx_byte     = owner_data;
                if ((tx_valid && owner_last) || expire) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    rr_ptr_d  = after_owner;
                    timeout_d = expire;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o   = grant_q;
    assign busy_o    = (state_q == LOCK);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (N_REQ=4, TIMEOUT_CYCLES=8).
// Requester sources are byte queues; every byte queued is also pushed, in
// the service order the arbitration rules dictate, onto exp_q as
// {one-hot owner, byte} and popped whenever tx_valid is seen.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 12;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   req_valid_i;
    logic [N*8-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic           fifo_tx_full;
    logic [7:0]     tx_byte;
    logic           tx_valid;
    logic [N-1:0]   grant_o;
    logic           busy_o;
    logic           timeout_o;

    uart_tx_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_last_i   (req_last_i),
        .req_ready_o  (req_ready_o),
        .fifo_tx_full (fifo_tx_full),
        .tx_byte      (tx_byte),
        .tx_valid     (tx_valid),
        .grant_o      (grant_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [8:0]   src_q [N][$];
    logic [W-1:0] exp_q[$];
    logic [N-1:0] acc;
    logic         full_nxt;
    int           n_checks;
    int           n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive();
        logic [8:0] head;
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() != 0) begin
                head = src_q[k][0];
                req_valid_i[k]         = 1'b1;
                req_data_i[8*k +: 8]   = head[7:0];
                req_last_i[k]          = head[8];
            end else begin
                req_valid_i[k]         = 1'b0;
                req_data_i[8*k +: 8]   = 8'h00;
                req_last_i[k]          = 1'b0;
            end
        end
    endtask

    task automatic send_pkt(input int k, input logic [7:0] base, input int len, input bit with_last);
        logic [3:0] oh;
        logic [7:0] b;
        logic       l;
        oh = 4'(1) << k;
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i);
            l = with_last && (i == len - 1);
            src_q[k].push_back({l, b});
            exp_q.push_back({oh, b});
        end
    endtask

    function automatic bit any_src();
        bit r;
        r = 1'b0;
        for (int k = 0; k < N; k++) if (src_q[k].size() != 0) r = 1'b1;
        return r;
    endfunction

    task automatic flush();
        for (int k = 0; k < N; k++) src_q[k].delete();
        exp_q.delete();
        acc          = '0;
        full_nxt     = 1'b0;
        fifo_tx_full = 1'b0;
        drive();
    endtask

    // One clock: pop accepted bytes and re-drive just after the edge, then
    // sample handshakes and the TX port at the falling edge.
    task automatic tick();
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (acc[k]) void'(src_q[k].pop_front());
        fifo_tx_full = full_nxt;
        drive();
        @(negedge clk);
        acc = req_valid_i & req_ready_o;
        if (tx_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("tx_extra", 32'(tx_valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("tx_owner_byte", 32'({grant_o, tx_byte}), 32'(e));
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy_o || exp_q.size() != 0 || any_src()) && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'(0));
        check_eq("drain_busy", 32'(busy_o), 32'(0));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        flush();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        flush();
        repeat (2) @(negedge clk);

        // Reset values
        check_eq("rst_grant", 32'(grant_o), 32'(0));
        check_eq("rst_busy", 32'(busy_o), 32'(0));
        check_eq("rst_tx_valid", 32'(tx_valid), 32'(0));
        check_eq("rst_ready", 32'(req_ready_o), 32'(0));
        check_eq("rst_timeout", 32'(timeout_o), 32'(0));
        check_eq("rst_tx_byte", 32'(tx_byte), 32'(0));
        reset_n = 1'b1;

        // Single requester: req1 sends A1,A2,A3
        send_pkt(1, 8'hA1, 3, 1'b1);
        tick();
        check_eq("single_idle_grant", 32'(grant_o), 32'(0));
        check_eq("single_idle_ready", 32'(req_ready_o), 32'(0));
        check_eq("single_idle_txv", 32'(tx_valid), 32'(0));
        tick();
        check_eq("single_grant", 32'(grant_o), 32'(4'b0010));
        tick();
        tick();
        tick();
        check_eq("single_done_busy", 32'(busy_o), 32'(0));
        check_eq("single_done_grant", 32'(grant_o), 32'(0));
        check_eq("single_drain", 32'(exp_q.size()), 32'(0));

        // Round-robin order from reset: 0,1,2,3,0 with one bubble each
        apply_reset();
        send_pkt(0, 8'h00, 2, 1'b1);
        send_pkt(1, 8'h10, 2, 1'b1);
        send_pkt(2, 8'h20, 2, 1'b1);
        send_pkt(3, 8'h30, 2, 1'b1);
        send_pkt(0, 8'h40, 2, 1'b1);
        tick();
        check_eq("rr_first_idle", 32'(grant_o), 32'(0));
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 2; b++) begin
                tick();
                check_eq("rr_grant", 32'(grant_o), 32'(1) << (p % 4));
            end
            tick();
            check_eq("rr_bubble", 32'(grant_o), 32'(0));
        end
        wait_idle(10);

        // Backpressure: 5 full cycles mid-packet (pointer now at 1)
        send_pkt(1, 8'hB0, 4, 1'b1);
        tick();
        check_eq("bp_idle", 32'(grant_o), 32'(0));
        tick();
        check_eq("bp_grant", 32'(grant_o), 32'(4'b0010));
        full_nxt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_tx_valid", 32'(tx_valid), 32'(0));
            check_eq("bp_ready", 32'(req_ready_o), 32'(0));
            check_eq("bp_grant_held", 32'(grant_o), 32'(4'b0010));
        end
        full_nxt = 1'b0;
        wait_idle(20);

        // No interleave: req2 owns a 4-byte packet, req0 and req3 arrive
        send_pkt(2, 8'hC0, 4, 1'b1);
        tick();
        tick();
        check_eq("ni_grant", 32'(grant_o), 32'(4'b0100));
        send_pkt(3, 8'hD0, 2, 1'b1);
        send_pkt(0, 8'hE0, 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("ni_hold", 32'(grant_o), 32'(4'b0100));
        end
        tick();
        check_eq("ni_bubble", 32'(grant_o), 32'(0));
        tick();
        check_eq("ni_wrap_to_3", 32'(grant_o), 32'(4'b1000));
        wait_idle(20);

        // Reset mid-packet (pointer now at 1, req2 packet)
        send_pkt(2, 8'h50, 4, 1'b1);
        tick();
        tick();
        tick();
        check_eq("mr_busy_before", 32'(busy_o), 32'(1));
        reset_n = 1'b0;
        #1;
        check_eq("mr_grant", 32'(grant_o), 32'(0));
        check_eq("mr_tx_valid", 32'(tx_valid), 32'(0));
        check_eq("mr_busy", 32'(busy_o), 32'(0));
        check_eq("mr_ready", 32'(req_ready_o), 32'(0));
        flush();
        @(negedge clk);
        reset_n = 1'b1;
        send_pkt(1, 8'h70, 2, 1'b1);
        send_pkt(2, 8'h60, 2, 1'b1);
        tick();
        check_eq("mr_post_idle", 32'(grant_o), 32'(0));
        tick();
        check_eq("mr_post_grant", 32'(grant_o), 32'(4'b0010));
        wait_idle(20);

        // Owner stalls mid-packet after one byte (pointer now at 3)
        send_pkt(0, 8'h80, 1, 1'b0);
        tick();
        tick();
        check_eq("stall_grant", 32'(grant_o), 32'(4'b0001));
`ifdef UART_ARB_TIMEOUT_EN
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (timeout_o) seen++;
            end
            check_eq("wd_pulses", 32'(seen), 32'(1));
            check_eq("wd_busy", 32'(busy_o), 32'(0));
            send_pkt(1, 8'h90, 1, 1'b1);
            send_pkt(0, 8'h91, 1, 1'b1);
            tick();
            tick();
            check_eq("wd_next_grant", 32'(grant_o), 32'(4'b0010));
            wait_idle(20);
        end
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("stall_timeout", 32'(timeout_o), 32'(0));
        end
        check_eq("stall_held_grant", 32'(grant_o), 32'(4'b0001));
        check_eq("stall_held_busy", 32'(busy_o), 32'(1));
        send_pkt(0, 8'h81, 1, 1'b1);
        wait_idle(20);
`endif

        check_eq("end_timeout", 32'(timeout_o), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
